// File: rtl/led_demux_seq.sv
// led_demux_seq: registered 1-to-CHANNELS LED demultiplexer.
// It has four modes. DIRECT routes the switch straight to the selected LED.
// LATCH toggles the selected LED on each rising edge of the switch.
// SCAN steps through the LEDs at a prescaled rate. HOLD freezes the outputs.
module led_demux_seq #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int SCAN_DIV = 4,
    parameter int DIV_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_sw,
    input  logic [SEL_W-1:0]    select,
    input  logic [1:0]          mode,
    input  logic                clear,
    output logic [CHANNELS-1:0] led,
    output logic [SEL_W-1:0]    active_ch
);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_LATCH  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    mode_e                mode_cur;
    mode_e                mode_q;
    logic                 in_q;
    logic [CHANNELS-1:0]  led_q,   led_n;
    logic [SEL_W-1:0]     act_q,   act_n;
    logic [SEL_W-1:0]     ptr_q,   ptr_n;
    logic [DIV_W-1:0]     cnt_q,   cnt_n;
    logic                 rise;
    logic                 mode_chg;
    logic                 sel_ok;
    logic [CHANNELS-1:0]  sel_hot;
    logic [CHANNELS-1:0]  ptr_hot;

    // One-hot decode of an index; out-of-range indices decode to all zeros.
    function automatic logic [CHANNELS-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [CHANNELS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (idx == SEL_W'(i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    assign mode_cur  = mode_e'(mode);
    assign rise      = in_sw & ~in_q;
    assign mode_chg  = (mode_cur != mode_q);
    assign sel_ok    = (32'(select) < CHANNELS);
    assign sel_hot   = onehot(select);
    assign ptr_hot   = onehot(ptr_q);
    assign led       = led_q;
    assign active_ch = act_q;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= 1'b0;
            mode_q <= MODE_DIRECT;
            led_q  <= '0;
            act_q  <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            in_q   <= in_sw;
            mode_q <= mode_cur;
            led_q  <= led_n;
            act_q  <= act_n;
            ptr_q  <= ptr_n;
            cnt_q  <= cnt_n;
        end
    end

    // Next-state: mode action, overridden on a mode-change cycle.
    // On a mode change, active_ch still follows the new mode's rule.
    // ptr is always 0 when SCAN is entered, so active_ch <= ptr gives 0.
    always_comb begin
        led_n = led_q;
        act_n = act_q;
        ptr_n = ptr_q;
        cnt_n = cnt_q;
        unique case (mode_cur)
            MODE_DIRECT: begin
                led_n = in_sw ? sel_hot : '0;
                act_n = select;
            end
            MODE_LATCH: begin
                if (clear)              led_n = '0;
                else if (rise && sel_ok) led_n = led_q ^ sel_hot;
                act_n = select;
            end
            MODE_SCAN: begin
                led_n = in_sw ? ptr_hot : '0;
                act_n = ptr_q;
                if (cnt_q == DIV_W'(SCAN_DIV - 1)) begin
                    cnt_n = '0;
                    ptr_n = (ptr_q == SEL_W'(CHANNELS - 1)) ? '0 : ptr_q + 1'b1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            MODE_HOLD: begin
            end
            default: begin
            end
        endcase
        if (mode_chg) begin
            led_n = '0;
            cnt_n = '0;
            ptr_n = '0;
        end
    end

endmodule

// File: tb/tb_led_demux_seq.sv
// tb_led_demux_seq: directed-vector bench for led_demux_seq.
// The main instance uses the default parameters (4 channels, SCAN_DIV=4).
// A second instance with 3 channels covers the out-of-range select case.
module tb_led_demux_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_sw;
    logic [1:0] select;
    logic [1:0] mode;
    logic       clear;
    logic [3:0] led;
    logic [1:0] active_ch;
    logic [2:0] led3;
    logic [1:0] active_ch3;

    int n_vec  = 0;
    int n_miss = 0;

    led_demux_seq #(.CHANNELS(4), .SEL_W(2), .SCAN_DIV(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .in_sw(in_sw), .select(select), .mode(mode),
        .clear(clear), .led(led), .active_ch(active_ch)
    );

    led_demux_seq #(.CHANNELS(3), .SEL_W(2), .SCAN_DIV(4), .DIV_W(8)) dut3 (
        .clk(clk), .rst(rst), .in_sw(in_sw), .select(select), .mode(mode),
        .clear(clear), .led(led3), .active_ch(active_ch3)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_sw = 1'b1; mode = 2'b00; select = 2'd2; clear = 1'b0;
        #1;
        tick();
        check("rst_led", 32'(led), 32'h0);
        check("rst_act", 32'(active_ch), 32'h0);
        rst = 1'b0;
        tick();
        check("rel_led", 32'(led), 32'h4);
        check("rel_act", 32'(active_ch), 32'h2);

        // DIRECT sweep
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            in_sw  = 1'b1;
            tick();
            check("dir_first", 32'(led), 32'(1) << s);
            check("dir_act", 32'(active_ch), 32'(s));
            check("dir3_led", 32'(led3), (s < 3) ? (32'(1) << s) : 32'h0);
            repeat (9) tick();
            check("dir_last", 32'(led), 32'(1) << s);
            in_sw = 1'b0;
            tick();
            check("dir_off", 32'(led), 32'h0);
        end

        // LATCH toggle
        mode = 2'b01; select = 2'd1; in_sw = 1'b0;
        tick();
        check("lat_enter", 32'(led), 32'h0);
        check("lat_enter_act", 32'(active_ch), 32'h1);
        in_sw = 1'b1;
        tick();
        check("lat_tog1", 32'(led), 32'h2);
        repeat (4) tick();
        check("lat_held", 32'(led), 32'h2);
        in_sw = 1'b0; tick();
        in_sw = 1'b1; tick();
        check("lat_tog2", 32'(led), 32'h0);
        in_sw = 1'b0; tick();
        select = 2'd3; in_sw = 1'b1; tick();
        check("lat_sel3", 32'(led), 32'h8);
        in_sw = 1'b0; tick();
        select = 2'd1; in_sw = 1'b1; tick();
        check("lat_1010", 32'(led), 32'hA);
        in_sw = 1'b0; tick();
        clear = 1'b1; in_sw = 1'b1; tick();
        check("lat_clr", 32'(led), 32'h0);
        clear = 1'b0; tick();
        check("lat_noretog", 32'(led), 32'h0);
        in_sw = 1'b0; tick();
        in_sw = 1'b1; tick(); in_sw = 1'b0; tick();
        select = 2'd3; in_sw = 1'b1; tick(); in_sw = 1'b0; tick();
        check("lat_rebuild", 32'(led), 32'hA);

        // HOLD freezes at zero, active_ch holds
        mode = 2'b11; select = 2'd0; tick();
        check("hold_led", 32'(led), 32'h0);
        check("hold_act", 32'(active_ch), 32'h3);
        in_sw = 1'b1; tick(); in_sw = 1'b0; tick(); tick();
        check("hold_stay", 32'(led), 32'h0);
        check("hold_act2", 32'(active_ch), 32'h3);
        mode = 2'b01; tick();
        check("hold2lat", 32'(led), 32'h0);
        check("hold2lat_act", 32'(active_ch), 32'h0);

        // Rise coincident with the mode change into LATCH
        mode = 2'b00; in_sw = 1'b0; tick();
        mode = 2'b01; select = 2'd2; in_sw = 1'b1; tick();
        check("chg_rise", 32'(led), 32'h0);
        in_sw = 1'b0; tick();
        check("chg_rise2", 32'(led), 32'h0);
        in_sw = 1'b1; tick();
        check("chg_next", 32'(led), 32'h4);
        in_sw = 1'b0; tick();

        // SCAN wrap
        mode = 2'b10; in_sw = 1'b1; tick();
        check("scan_enter", 32'(led), 32'h0);
        check("scan_enter_act", 32'(active_ch), 32'h0);
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check("scan_led", 32'(led), 32'(1) << (k % 4));
                check("scan_act", 32'(active_ch), 32'(k % 4));
            end
        end
        in_sw = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("scan_off_led", 32'(led), 32'h0);
            check("scan_off_act", 32'(active_ch), 32'h1);
        end
        // ptr is now 2: detour through DIRECT and back
        mode = 2'b00; select = 2'd1; tick();
        check("detour_led", 32'(led), 32'h0);
        check("detour_act", 32'(active_ch), 32'h1);
        mode = 2'b10; in_sw = 1'b1; tick();
        check("rescan_chg", 32'(led), 32'h0);
        tick();
        check("rescan_led", 32'(led), 32'h1);
        check("rescan_act", 32'(active_ch), 32'h0);
        repeat (13) tick();
        check("pre_rst_led", 32'(led), 32'h8);
        check("pre_rst_act", 32'(active_ch), 32'h3);

        // Reset mid-scan (ptr=3, cnt=2)
        rst = 1'b1; tick();
        check("mid_rst_led", 32'(led), 32'h0);
        check("mid_rst_act", 32'(active_ch), 32'h0);
        rst = 1'b0; tick();
        check("post_rst_chg", 32'(led), 32'h0);
        repeat (4) tick();
        check("post_rst_step0", 32'(led), 32'h1);
        tick();
        check("post_rst_step1", 32'(led), 32'h2);
        check("post_rst_act1", 32'(active_ch), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
